// File: rtl/sqrt_reduce_pipe.sv
// sqrt_reduce_pipe: N-channel pipelined restoring integer square root with sum/max reduction.
module sqrt_reduce_pipe #(
  parameter  int N_CH = 3,
  parameter  int W    = 32,
  localparam int RW   = W / 2,
  localparam int SW   = N_CH == 1 ? RW : RW + $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arg_vld,
  input  logic [N_CH*W-1:0] arg,
  input  logic [N_CH-1:0]   ch_en,
  input  logic              op,
  output logic              res_vld,
  output logic [SW-1:0]     res,
  output logic              busy
);
  logic [RW-1:0]        v_q, v_d, op_q, op_d;
  logic [N_CH-1:0]      en_q [RW], en_d [RW];
  logic [N_CH*RW-1:0]   roots;
  logic                 res_vld_q, res_vld_d, busy_q, busy_d;
  logic [SW-1:0]        res_q, res_d, sum, mx, rt;

  always_comb begin
    v_d = {v_q[RW-2:0], arg_vld};
    en_d = en_q;
    op_d = op_q;
    en_d[0] = arg_vld ? ch_en : en_q[0];
    op_d[0] = arg_vld ? op : op_q[0];
    for (int k = 1; k < RW; k++) begin
      en_d[k] = v_q[k-1] ? en_q[k-1] : en_q[k];
      op_d[k] = v_q[k-1] ? op_q[k-1] : op_q[k];
    end
  end

  // Each stage shifts in two operand bits and resolves one root bit; disabled lanes hold.
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [RW+1:0] rem_q [RW], rem_d [RW], rem_i [RW], nxt [RW];
    logic [RW-1:0] root_q [RW], root_d [RW], root_i [RW];
    logic [W-1:0]  opd_q [RW], opd_d [RW], opd_i [RW];
    logic [RW+3:0] cur [RW];
    logic [RW-1:0] ld, ge;
    always_comb begin
      rem_i[0] = '0;
      root_i[0] = '0;
      opd_i[0] = arg[c*W +: W];
      ld[0] = arg_vld & ch_en[c];
      for (int k = 1; k < RW; k++) begin
        rem_i[k] = rem_q[k-1];
        root_i[k] = root_q[k-1];
        opd_i[k] = opd_q[k-1];
        ld[k] = v_q[k-1] & en_q[k-1][c];
      end
      for (int k = 0; k < RW; k++) begin
        cur[k] = {rem_i[k], opd_i[k][W-1 -: 2]};
        ge[k] = cur[k] >= {2'b00, root_i[k], 2'b01};
        nxt[k] = ge[k] ? cur[k][RW+1:0] - {root_i[k], 2'b01} : cur[k][RW+1:0];
        rem_d[k] = ld[k] ? nxt[k] : rem_q[k];
        root_d[k] = ld[k] ? {root_i[k][RW-2:0], ge[k]} : root_q[k];
        opd_d[k] = ld[k] ? opd_i[k] << 2 : opd_q[k];
      end
    end
    always_ff @(posedge clk) begin
      rem_q <= rem_d;
      root_q <= root_d;
      opd_q <= opd_d;
    end
    assign roots[c*RW +: RW] = root_q[RW-1];
  end

  always_comb begin
    sum = '0;
    mx = '0;
    rt = '0;
    for (int c = 0; c < N_CH; c++) begin
      rt = en_q[RW-1][c] ? SW'(roots[c*RW +: RW]) : '0;
      sum = sum + rt;
      mx = rt > mx ? rt : mx;
    end
    res_d = v_q[RW-1] ? (op_q[RW-1] ? mx : sum) : res_q;
    res_vld_d = v_q[RW-1];
    busy_d = arg_vld | (|v_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      res_vld_q <= 1'b0;
      res_q <= '0;
      busy_q <= 1'b0;
    end else begin
      v_q <= v_d;
      res_vld_q <= res_vld_d;
      res_q <= res_d;
      busy_q <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    en_q <= en_d;
    op_q <= op_d;
  end

  assign res_vld = res_vld_q;
  assign res = res_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_sqrt_reduce_pipe.sv
// tb_sqrt_reduce_pipe: scoreboard bench for the 3-channel 32-bit sqrt reduction pipe.
module tb_sqrt_reduce_pipe;
  localparam int N = 3, W = 32, RW = 16, SW = 18;
  typedef struct { longint r; int due; } exp_t;

  logic clk = 0, rst_n = 1, arg_vld = 0, op = 0;
  logic [N*W-1:0] arg = '0;
  logic [N-1:0] ch_en = '0;
  logic res_vld, busy;
  logic [SW-1:0] res;
  int total = 0, bad = 0, cyc = 0;
  exp_t q[$];
  longint p0, p2r, p2m;

  sqrt_reduce_pipe #(.N_CH(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .arg_vld(arg_vld), .arg(arg), .ch_en(ch_en),
    .op(op), .res_vld(res_vld), .res(res), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at cyc %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic longint isqrt(input longint x);
    longint r = 0, t;
    for (int b = 15; b >= 0; b--) begin
      t = r | (longint'(1) << b);
      if (t * t <= x) r = t;
    end
    return r;
  endfunction

  function automatic longint model(input logic [N*W-1:0] a, input logic [N-1:0] e, input logic o);
    longint s = 0, m = 0, r;
    for (int c = 0; c < N; c++)
      if (e[c]) begin
        r = isqrt(longint'(a[c*W +: W]));
        s += r;
        if (r > m) m = r;
      end
    return o ? m : s;
  endfunction

  task automatic send(input logic [N*W-1:0] a, input logic [N-1:0] e, input logic o);
    exp_t x;
    @(negedge clk);
    arg_vld = 1; arg = a; ch_en = e; op = o;
    x.r = model(a, e, o);
    x.due = cyc + RW + 1;
    q.push_back(x);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk) begin
      arg_vld = 0;
      arg = {$urandom, $urandom, $urandom};
      ch_en = N'($urandom);
      op = 1'($urandom);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n) begin
      if (res_vld) begin
        if (q.size() == 0) chk("extra_vld", 1, 0);
        else begin
          e = q.pop_front();
          chk("res", res, e.r);
          chk("lat", cyc, e.due);
        end
      end else if (q.size() != 0 && q[0].due <= cyc) begin
        chk("no_vld", 0, 1);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    logic [N*W-1:0] a;
    #3 rst_n = 0;
    repeat (3) @(negedge clk);
    chk("rst_vld", res_vld, 0);
    chk("rst_res", res, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1;
    send({32'd36, 32'd25, 32'd16}, 3'b111, 1'b0);
    for (int i = 1; i <= 18; i++) begin
      @(negedge clk);
      arg_vld = 0;
      chk("busy", busy, i <= 17);
    end
    send({32'd36, 32'd25, 32'd16}, 3'b111, 1'b1);
    send({32'd15, 32'd8, 32'd3}, 3'b111, 1'b1);
    idle(20);
    p0 = dut.g_ch[0].opd_q[0];
    p2r = dut.g_ch[2].root_q[RW-1];
    p2m = dut.g_ch[2].rem_q[RW-1];
    send({32'd81, 32'd49, 32'd100}, 3'b010, 1'b0);
    idle(20);
    chk("gate_c0_opd", dut.g_ch[0].opd_q[0], p0);
    chk("gate_c2_root", dut.g_ch[2].root_q[RW-1], p2r);
    chk("gate_c2_rem", dut.g_ch[2].rem_q[RW-1], p2m);
    send({3{32'hFFFF_FFFF}}, 3'b111, 1'b0);
    send('0, 3'b111, 1'b0);
    send({32'hFFFE_0001, 32'hFFFE_0000, 32'd1}, 3'b111, 1'b0);
    send({32'hFFFE_0001, 32'hFFFE_0000, 32'd1}, 3'b000, 1'b1);
    for (int i = 0; i < 200; i++) begin
      a = {$urandom, $urandom, $urandom};
      if (i % 4 == 0) a &= {3{32'h0000_FFFF}};
      send(a, N'($urandom), 1'($urandom));
    end
    for (int i = 0; i < 50; i++) begin
      send({$urandom, $urandom, $urandom}, N'($urandom), 1'($urandom));
      idle($urandom_range(0, 3));
    end
    idle(20);
    chk("drain", q.size(), 0);
    for (int i = 0; i < 5; i++) send({$urandom, $urandom, $urandom}, 3'b111, 1'b0);
    @(negedge clk);
    arg_vld = 0;
    #2 rst_n = 0;
    q.delete();
    #1;
    chk("mid_rst_vld", res_vld, 0);
    chk("mid_rst_res", res, 0);
    chk("mid_rst_busy", busy, 0);
    repeat (3) @(negedge clk);
    #3 rst_n = 1;
    idle(25);
    send({32'd4, 32'd9, 32'd16}, 3'b111, 1'b0);
    idle(20);
    chk("final_drain", q.size(), 0);
    chk("final_busy", busy, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sqrt_reduce_pipe.md
Name: sqrt_reduce_pipe

Overview:
- Parametrised N-channel integer-square-root reduction pipeline.
- Each cycle it accepts N_CH unsigned W-bit operands and computes floor(sqrt) of every enabled channel in an internal fully pipelined isqrt array.
- It then reduces the roots to one result, either their sum or their maximum, with a fixed latency.
- It is the generalised successor of the fixed three-channel 32-bit sqrt-sum block. It adds a channel-enable mask, a selectable reduction op and a busy indicator.

Parameters:
- N_CH, 3: number of input channels; range 1..8.
- W, 32: operand width in bits; even, range 4..32.
- RW, W/2: root width (derived; not to be overridden).
- SW, RW+$clog2(N_CH) (RW when N_CH=1): result width (derived).

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- arg_vld  in  1  operand set valid; one set accepted per cycle, no backpressure.
- arg  in  N_CH*W  packed operands; channel i is arg[i*W +: W], unsigned.
- ch_en  in  N_CH  per-channel enable, sampled with arg_vld.
- op  in  1  reduction op sampled with arg_vld: 0 = sum, 1 = max.
- res_vld  out  1  result valid, single-cycle pulse per accepted set.
- res  out  SW  reduction result, zero-extended.
- busy  out  1  high while any accepted set is still in flight.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: res_vld=0, res=0, busy=0, and all pipeline valid bits cleared.
- Data registers are not reset. They hold their value until loaded.
- isqrt array:
  - RW stages per channel, restoring digit-by-digit: stage k resolves root bit RW-1-k.
  - Each stage registers the remainder, partial root and remaining operand bits.
  - Per-stage valid bit v[k]: v[0] <= arg_vld, v[k] <= v[k-1].
- Dynamic-power rules:
  - A channel's stage-k data registers load only when v[k-1] is high AND that channel's ch_en bit (carried down the pipe) is 1.
  - Otherwise they hold. No data register toggles on an idle cycle.
- Sideband: ch_en and op travel alongside the data, in registers gated by the same valid bits.
- Reduction stage (1 cycle, registered into res, loaded only when v[RW-1]=1):
  - op=0: res <= sum over enabled channels of root_i. Disabled channels contribute 0.
  - op=1: res <= max over enabled channels of root_i. Ties are irrelevant. With no channel enabled, the result is 0.
- res_vld <= v[RW-1], so the latency is exactly RW+1 cycles from the arg_vld edge to the res_vld edge (17 for W=32).
- When res_vld=0, res holds its last value.
- Throughput: one set per cycle, indefinitely. Back-to-back and gapped streams keep ordering and fixed latency.
- Width: SW bits never overflow. The maximum sum is N_CH*(2^RW-1).
- Root: floor(sqrt(x)) for every x in 0..2^W-1, so 0->0 and 2^W-1 -> 2^RW-1.
- busy is a registered OR of all v[k] and res_vld's source: busy is 1 in every cycle in which a set is between acceptance and its res_vld.
- busy falls in the cycle after the last res_vld.
- Reset mid-operation: all in-flight sets are discarded and no res_vld occurs for them.
- The first arg_vld after rst_n deasserts behaves as from a clean pipe.
- Inputs other than clk and rst_n are ignored when arg_vld=0.
- There is no X propagation to res on res_vld=1.

Test Plan:
- W=32, N_CH=3, op=0, ch_en=3'b111, arg={36,25,16}, single pulse -> res_vld is high exactly 17 cycles later with res=15; busy is high for those cycles, then 0.
- op=1, same operands -> res=6. Then arg={15,8,3} with op=1 -> res=3 (floors 3,2,1).
- ch_en=3'b010, arg={81,49,100}, op=0 -> res=7. Probe: channels 0 and 2 stage registers show no toggles.
- All channels 0xFFFFFFFF, op=0 -> res=196605 (0x2FFFD). All zero -> res=0.
- 200 back-to-back random sets with random ch_en/op, plus 50 sets with random gaps -> results match a reference model in order, each exactly 17 cycles after its input, and no extra res_vld.
- 5 sets in flight, rst_n pulsed low asynchronously mid-cycle -> res_vld, res and busy go to 0 immediately. No stale res_vld appears afterward. A new set {4,9,16} yields res=9 after 17 cycles.
